// File: rtl/mont_mul_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared
// Montgomery multiplier.
// Ports:
//   requester side : i_req0/1, i_a0/b0, i_a1/b1 in; o_grant0/1, o_done0/1, o_result out
//   multiplier side: o_mul_start, o_mul_a, o_mul_b out; i_mul_result, i_mul_finished in
// Modport slave is the arbiter; modport master is everything around it.
interface mont_mul_arbiter_if #(
    parameter int WIDTH = 256
);
    logic             i_req0;
    logic             i_req1;
    logic [WIDTH-1:0] i_a0;
    logic [WIDTH-1:0] i_b0;
    logic [WIDTH-1:0] i_a1;
    logic [WIDTH-1:0] i_b1;
    logic             o_grant0;
    logic             o_grant1;
    logic             o_done0;
    logic             o_done1;
    logic [WIDTH-1:0] o_result;
    logic             o_mul_start;
    logic [WIDTH-1:0] o_mul_a;
    logic [WIDTH-1:0] o_mul_b;
    logic [WIDTH-1:0] i_mul_result;
    logic             i_mul_finished;

    modport slave (
        input  i_req0, i_req1, i_a0, i_b0, i_a1, i_b1,
        input  i_mul_result, i_mul_finished,
        output o_grant0, o_grant1, o_done0, o_done1, o_result,
        output o_mul_start, o_mul_a, o_mul_b
    );

    modport master (
        output i_req0, i_req1, i_a0, i_b0, i_a1, i_b1,
        output i_mul_result, i_mul_finished,
        input  o_grant0, o_grant1, o_done0, o_done1, o_result,
        input  o_mul_start, o_mul_a, o_mul_b
    );
endinterface

// File: rtl/mont_mul_arbiter.sv
// Two-requester arbiter in front of one shared Montgomery multiplier.
// Ports: i_clk, i_rst (async, active high), bus (mont_mul_arbiter_if.slave).
// Round-robin by default; defining MONT_ARB_FIXED_PRIO_EN makes
// requester 0 win every tie instead.
module mont_mul_arbiter #(
    parameter int WIDTH = 256
) (
    input logic               i_clk,
    input logic               i_rst,
    mont_mul_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t           state;
    logic             pend0;
    logic             pend1;
    logic             last;
    logic             win;
    logic             acc0;
    logic             acc1;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    always_comb begin
`ifdef MONT_ARB_FIXED_PRIO_EN
        win = ~pend0;
`else
        win = (pend0 & pend1) ? ~last : ~pend0;
`endif
        win_a = win ? bus.i_a1 : bus.i_a0;
        win_b = win ? bus.i_b1 : bus.i_b0;
        // a request that coincides with its own grant pulse is dropped
        acc0 = bus.i_req0 & ~bus.o_grant0;
        acc1 = bus.i_req1 & ~bus.o_grant1;
    end

    // 'last' doubles as the owner of the operation in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            pend0           <= 1'b0;
            pend1           <= 1'b0;
            last            <= 1'b1;
            bus.o_mul_start <= 1'b0;
            bus.o_grant0    <= 1'b0;
            bus.o_grant1    <= 1'b0;
            bus.o_done0     <= 1'b0;
            bus.o_done1     <= 1'b0;
            bus.o_result    <= '0;
            bus.o_mul_a     <= '0;
            bus.o_mul_b     <= '0;
        end else begin
            bus.o_mul_start <= 1'b0;
            bus.o_grant0    <= 1'b0;
            bus.o_grant1    <= 1'b0;
            bus.o_done0     <= 1'b0;
            bus.o_done1     <= 1'b0;
            if (acc0) pend0 <= 1'b1;
            if (acc1) pend1 <= 1'b1;
            unique case (state)
                IDLE, DONE: begin
                    if (pend0 | pend1) begin
                        state           <= START;
                        last            <= win;
                        bus.o_mul_a     <= win_a;
                        bus.o_mul_b     <= win_b;
                        bus.o_mul_start <= 1'b1;
                        // a fresh request on the grant edge re-arms pending
                        if (win) begin
                            bus.o_grant1 <= 1'b1;
                            pend1        <= bus.i_req1;
                        end else begin
                            bus.o_grant0 <= 1'b1;
                            pend0        <= bus.i_req0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                START: state <= BUSY;
                BUSY: begin
                    if (bus.i_mul_finished) begin
                        bus.o_result <= bus.i_mul_result;
                        bus.o_done0  <= ~last;
                        bus.o_done1  <= last;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Self-checking bench for mont_mul_arbiter: directed scenarios plus a
// randomized run compared every cycle against a transaction-level model.
module tb_mont_mul_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mont_mul_arbiter_if #(.WIDTH(W)) bus ();
    mont_mul_arbiter #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    bit   [1:0]   req;
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    logic         fin;
    logic [W-1:0] mres;

    assign bus.i_req0         = req[0];
    assign bus.i_req1         = req[1];
    assign bus.i_a0           = a[0];
    assign bus.i_b0           = b[0];
    assign bus.i_a1           = a[1];
    assign bus.i_b1           = b[1];
    assign bus.i_mul_finished = fin;
    assign bus.i_mul_result   = mres;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cnt   = 0;
    int lat   = 4;
    bit spur  = 1'b0;
    logic [W-1:0] prod;

    int           g_who[$];
    int           g_cyc[$];
    int           d_who[$];
    int           d_cyc[$];
    logic [W-1:0] d_res[$];

    // model: phase 0 idle, 1 start, 2 busy, 3 done
    int           m_phase;
    bit   [1:0]   m_pend;
    int           m_own;
    bit   [1:0]   m_gnt;
    bit   [1:0]   m_done;
    bit           m_start;
    logic [W-1:0] m_ma, m_mb, m_res;

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pend  = 2'b00;
        m_own   = 1;
        m_gnt   = 2'b00;
        m_done  = 2'b00;
        m_start = 1'b0;
        m_ma    = '0;
        m_mb    = '0;
        m_res   = '0;
    endtask

    function automatic int pick(input bit [1:0] p, input int lst);
        if (p == 2'b11) begin
`ifdef MONT_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - lst;
`endif
        end
        return p[0] ? 0 : 1;
    endfunction

    // advance the model by one clock edge using the inputs now applied
    task automatic model_step();
        bit [1:0] pb;
        bit [1:0] gp;
        int       w;
        if (rst) begin
            model_reset();
            return;
        end
        pb      = m_pend;
        gp      = m_gnt;
        m_start = 1'b0;
        m_gnt   = 2'b00;
        m_done  = 2'b00;
        for (int k = 0; k < 2; k++)
            if (req[k] && !gp[k]) m_pend[k] = 1'b1;
        if ((m_phase == 0 || m_phase == 3) && pb != 2'b00) begin
            w         = pick(pb, m_own);
            m_own     = w;
            m_ma      = a[w];
            m_mb      = b[w];
            m_start   = 1'b1;
            m_gnt[w]  = 1'b1;
            m_pend[w] = req[w];
            m_phase   = 1;
        end else if (m_phase == 3) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && fin) begin
            m_res        = m_ma * m_mb;
            m_done[m_own] = 1'b1;
            m_phase      = 3;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("mul_start", bus.o_mul_start, m_start);
        check("grant0", bus.o_grant0, m_gnt[0]);
        check("grant1", bus.o_grant1, m_gnt[1]);
        check("done0", bus.o_done0, m_done[0]);
        check("done1", bus.o_done1, m_done[1]);
        check("result", bus.o_result, m_res);
        check("mul_a", bus.o_mul_a, m_ma);
        check("mul_b", bus.o_mul_b, m_mb);
        check("grant_excl", bus.o_grant0 & bus.o_grant1, 0);
        check("done_excl", bus.o_done0 & bus.o_done1, 0);
        if (bus.o_grant0) begin g_who.push_back(0); g_cyc.push_back(cyc); end
        if (bus.o_grant1) begin g_who.push_back(1); g_cyc.push_back(cyc); end
        if (bus.o_done0 || bus.o_done1) begin
            d_who.push_back(bus.o_done1 ? 1 : 0);
            d_cyc.push_back(cyc);
            d_res.push_back(bus.o_result);
        end
        req = 2'b00;
        // mock multiplier
        if (rst) begin
            cnt = 0;
            fin = 1'b0;
        end else if (bus.o_mul_start) begin
            cnt  = lat;
            prod = bus.o_mul_a * bus.o_mul_b;
            fin  = spur;
            mres = $urandom;
        end else begin
            fin = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    fin  = 1'b1;
                    mres = prod;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        g_who.delete();
        g_cyc.delete();
        d_who.delete();
        d_cyc.delete();
        d_res.delete();
    endtask

    task automatic wait_done(input int k, input int lim, input string nm);
        int n = 0;
        while (!(k == 0 ? bus.o_done0 : bus.o_done1) && n < lim) begin
            cycle();
            n++;
        end
        if (!(k == 0 ? bus.o_done0 : bus.o_done1)) fail(nm);
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int n = 0;
        while (!(m_phase == 0 && m_pend == 2'b00) && n < lim) begin
            cycle();
            n++;
        end
        if (!(m_phase == 0 && m_pend == 2'b00)) fail(nm);
    endtask

    int s;
    int exp034 [4];

    initial begin
        req  = 2'b00;
        a[0] = '0; b[0] = '0; a[1] = '0; b[1] = '0;
        fin  = 1'b0;
        mres = '0;
        prod = '0;
        model_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // single request: 3*5, finished 10 cycles after start
        lat = 10;
        a[0] = 3; b[0] = 5;
        req[0] = 1'b1;
        cycle();
        check("t1_not_yet", bus.o_mul_start, 0);
        cycle();
        check("t1_start", bus.o_mul_start, 1);
        check("t1_grant0", bus.o_grant0, 1);
        check("t1_mul_a", bus.o_mul_a, 3);
        s = cyc;
        wait_done(0, 40, "t1_done");
        check("t1_latency", cyc - s, 11);
        check("t1_result", bus.o_result, 15);

        // simultaneous requests after reset: 0 then 1, back to back
        wait_idle(20, "t2_idle");
        do_reset();
        clear_logs();
        lat = 3;
        a[0] = 7; b[0] = 9; a[1] = 11; b[1] = 13;
        req = 2'b11;
        cycle();
        wait_done(1, 80, "t2_done1");
        check("t2_ngrants", g_who.size(), 2);
        check("t2_ndones", d_who.size(), 2);
        if (g_who.size() == 2 && d_who.size() == 2) begin
            check("t2_first", g_who[0], 0);
            check("t2_second", g_who[1], 1);
            check("t2_done_order", d_who[0], 0);
            check("t2_no_idle", g_cyc[1], d_cyc[0] + 1);
            check("t2_res0", d_res[0], 63);
            check("t2_res1", d_res[1], 143);
        end

        // both keep re-requesting during every BUSY
`ifdef MONT_ARB_FIXED_PRIO_EN
        exp034 = '{0, 0, 0, 0};
`else
        exp034 = '{0, 1, 0, 1};
`endif
        wait_idle(40, "t3_idle");
        do_reset();
        clear_logs();
        lat = 4;
        req = 2'b11;
        s = 0;
        while (g_who.size() < 4 && s < 300) begin
            if (m_phase == 2) req = 2'b11;
            cycle();
            s++;
        end
        if (g_who.size() < 4) fail("t3_grants");
        else
            for (int i = 0; i < 4; i++)
                check($sformatf("t3_grant%0d", i), g_who[i], exp034[i]);

        // duplicate requests from 1 during one BUSY
        wait_idle(200, "t4_idle0");
        do_reset();
        clear_logs();
        lat = 10;
        req[0] = 1'b1;
        cycle();
        s = 0;
        while (m_phase != 2 && s < 10) begin cycle(); s++; end
        for (int i = 0; i < 6; i++) begin
            req[1] = (i % 2 == 0);
            cycle();
        end
        wait_idle(100, "t4_idle");
        check("t4_ngrants", g_who.size(), 2);
        check("t4_grants1", g_who.sum() with (item == 1 ? 1 : 0), 1);

        // reset in the middle of BUSY
        do_reset();
        clear_logs();
        lat = 10;
        a[0] = 2; b[0] = 21;
        req[0] = 1'b1;
        repeat (5) cycle();
        rst = 1'b1;
        #1;
        check("t5_start", bus.o_mul_start, 0);
        check("t5_grant0", bus.o_grant0, 0);
        check("t5_done0", bus.o_done0, 0);
        check("t5_result", bus.o_result, 0);
        check("t5_mul_a", bus.o_mul_a, 0);
        check("t5_mul_b", bus.o_mul_b, 0);
        model_reset();
        cycle();
        rst = 1'b0;
        repeat (15) cycle();
        check("t5_no_done", d_who.size(), 0);
        lat = 2;
        a[0] = 6; b[0] = 7;
        req[0] = 1'b1;
        cycle();
        wait_done(0, 20, "t5_done");
        check("t5_after", bus.o_result, 42);

        // finished pulsed during START is ignored
        wait_idle(20, "t6_idle");
        do_reset();
        clear_logs();
        lat = 5;
        spur = 1'b1;
        a[0] = 4; b[0] = 4;
        req[0] = 1'b1;
        cycle();
        cycle();
        s = cyc;
        wait_done(0, 40, "t6_done");
        check("t6_latency", cyc - s, 6);
        check("t6_result", bus.o_result, 16);
        spur = 1'b0;

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!m_pend[k] && $urandom_range(0, 3) == 0) begin
                    a[k] = $urandom;
                    b[k] = $urandom;
                end
                req[k] = ($urandom_range(0, 99) < 25);
            end
            lat  = $urandom_range(1, 8);
            spur = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 799) == 0) rst = 1'b1;
            cycle();
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
